irq_claim_ctrl: RTL and testbench
=================================

IRQ_CLAIM_CTRL -- requirements
Module: irq_claim_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 32, meaning the number of PLIC sources; ID 0 is reserved for "no interrupt".
REQ-002 The block SHALL have parameter ID_W, default 5, meaning the claim-ID width, equal to $clog2(NUM_SRC).
REQ-003 The block SHALL have parameter CLAIM_ADDR, default 32'h0020_0004, meaning the context-0 claim/complete register address.
REQ-004 The block SHALL have parameter RSP_TIMEOUT, default 255, meaning the maximum number of cycles to wait for a bus response.
REQ-005 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 ext_irq_i  in  1  level interrupt from the PLIC.
REQ-008 irq_en_i  in  1  combined mstatus.MIE & mie.MEIE from the CSR file.
REQ-009 bus_req_o  out  1  bus request valid.
REQ-010 bus_gnt_i  in  1  bus request accepted.
REQ-011 bus_we_o  out  1  1 = complete write, 0 = claim read.
REQ-012 bus_addr_o  out  32  always CLAIM_ADDR.
REQ-013 bus_wdata_o  out  32  completed ID, zero-extended.
REQ-014 bus_rvalid_i  in  1  response valid.
REQ-015 bus_rdata_i  in  32  claim read data.
REQ-016 trap_valid_o  out  1  external-interrupt trap request to the core.
REQ-017 trap_ready_i  in  1  core accepts the trap.
REQ-018 trap_id_o  out  ID_W  claimed source ID.
REQ-019 done_i  in  1  handler finished (one-cycle pulse, e.g. an MRET after the trap).
REQ-020 busy_o  out  1  FSM not in IDLE.
REQ-021 spurious_cnt_o  out  8  count of claims that returned ID 0, saturating.
REQ-022 timeout_o  out  1  sticky flag: a bus response timed out.

Function
REQ-023 FSM states SHALL be IDLE, CLAIM_REQ, CLAIM_WAIT, DISPATCH, SERVICE, CMPL_REQ, CMPL_WAIT.
REQ-024 IDLE -> CLAIM_REQ SHALL occur when ext_irq_i & irq_en_i are both high.
REQ-025 In CLAIM_REQ and CMPL_REQ, bus_req_o SHALL be 1, and bus_we_o SHALL be 0 (CLAIM_REQ) or 1 (CMPL_REQ).
REQ-026 Request signals SHALL hold stable until bus_gnt_i is seen; on grant the FSM SHALL move to the matching WAIT state.
REQ-027 In CLAIM_WAIT, on bus_rvalid_i: if rdata[ID_W-1:0] is nonzero and rdata is below NUM_SRC, the block SHALL register the ID and go to DISPATCH.
REQ-028 In CLAIM_WAIT, on bus_rvalid_i with any other value (ID 0 or out of range), the block SHALL return to IDLE and increment spurious_cnt_o, saturating at 255.
REQ-029 In DISPATCH, trap_valid_o SHALL be 1 with trap_id_o stable; on trap_ready_i the FSM SHALL go to SERVICE.
REQ-030 trap_valid_o SHALL NOT drop before trap_ready_i.
REQ-031 In SERVICE, done_i SHALL move the FSM to CMPL_REQ with bus_wdata_o equal to the held ID; ext_irq_i SHALL be ignored (no nesting).
REQ-032 CMPL_WAIT SHALL accept bus_rvalid_i as the write acknowledgement and go to IDLE.
REQ-033 A wait-cycle counter SHALL clear on entry to either WAIT state.
REQ-034 If the wait counter reaches RSP_TIMEOUT, the FSM SHALL go to IDLE and set timeout_o; timeout_o SHALL be cleared only by reset.
REQ-035 Latency from ext_irq_i rising to bus_req_o SHALL be 1 cycle; with zero-wait grant and response, trap_valid_o SHALL rise 3 cycles after bus_req_o.
REQ-036 done_i outside SERVICE SHALL be ignored.
REQ-037 If bus_rvalid_i and the timeout occur in the same cycle, the response SHALL win.
REQ-038 If irq_en_i drops after the claim is issued, the block SHALL still finish the claim and dispatch (the ID is owned).
REQ-039 All outputs SHALL be registered.

Reset
REQ-040 On rst_i assertion the FSM SHALL go to IDLE and all outputs, counters and held ID SHALL clear to 0, immediately and asynchronously, even mid-transaction.
REQ-041 Reset release SHALL be treated as synchronous to clk_i; the first transition may occur on the first rising edge after release.

Structure
REQ-042 The state enum, CLAIM_ADDR default and ID_W calculation SHALL live in the shared irq_pkg package.
REQ-043 The block SHALL be a single module with no sub-modules; the wait counter SHALL be inline.

Verification
REQ-044 Bench SHALL cover: ext_irq_i=1, irq_en_i=1, immediate gnt and rvalid, rdata=7 -> trap_valid_o with trap_id_o=7; then done_i -> complete write of bus_wdata_o=7, then IDLE.
REQ-045 Bench SHALL cover: rdata=0 on claim -> no trap, spurious_cnt_o increments by 1, and after 256 such events stays at 255.
REQ-046 Bench SHALL cover: no bus_rvalid_i for 255 cycles in CLAIM_WAIT -> return to IDLE, timeout_o=1 and remaining 1.
REQ-047 Bench SHALL cover: trap_ready_i held low 10 cycles -> trap_valid_o and trap_id_o stable throughout, done_i pulses during DISPATCH ignored.
REQ-048 Bench SHALL cover: rst_i asserted during CMPL_WAIT -> all outputs 0 in the same cycle, FSM in IDLE, no bus_req_o after release unless ext_irq_i is high.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the external-interrupt claim/complete controller.
package irq_pkg;

    localparam int unsigned NUM_SRC_DEFAULT     = 32;
    localparam logic [31:0] CLAIM_ADDR_DEFAULT  = 32'h0020_0004;
    localparam int unsigned RSP_TIMEOUT_DEFAULT = 255;

    // Claim-ID width for a given number of sources (never below one bit).
    function automatic int unsigned id_width(input int unsigned num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    localparam int unsigned ID_W_DEFAULT = id_width(NUM_SRC_DEFAULT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLAIM_REQ  = 3'd1,
        CLAIM_WAIT = 3'd2,
        DISPATCH   = 3'd3,
        SERVICE    = 3'd4,
        CMPL_REQ   = 3'd5,
        CMPL_WAIT  = 3'd6
    } irq_state_e;

endpackage

// File: rtl/irq_claim_ctrl.sv
// Claims an external interrupt from the PLIC, dispatches it to the core as a
// trap, and writes the completion back once the handler signals done.
// The bus response (rvalid/rdata) is registered on arrival, so with a
// zero-wait bus the trap request rises three cycles after the claim request.
module irq_claim_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC     = NUM_SRC_DEFAULT,
    parameter int unsigned ID_W        = id_width(NUM_SRC),
    parameter logic [31:0] CLAIM_ADDR  = CLAIM_ADDR_DEFAULT,
    parameter int unsigned RSP_TIMEOUT = RSP_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ext_irq_i,
    input  logic            irq_en_i,
    output logic            bus_req_o,
    input  logic            bus_gnt_i,
    output logic            bus_we_o,
    output logic [31:0]     bus_addr_o,
    output logic [31:0]     bus_wdata_o,
    input  logic            bus_rvalid_i,
    input  logic [31:0]     bus_rdata_i,
    output logic            trap_valid_o,
    input  logic            trap_ready_i,
    output logic [ID_W-1:0] trap_id_o,
    input  logic            done_i,
    output logic            busy_o,
    output logic [7:0]      spurious_cnt_o,
    output logic            timeout_o
);

    localparam int unsigned CNT_W = $clog2(RSP_TIMEOUT + 1);

    irq_state_e       state_q, state_nx;
    logic [ID_W-1:0]  id_q, id_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [7:0]       spur_nx;
    logic             tmo_nx;
    logic             rsp_vld_q;
    logic [31:0]      rsp_data_q;
    logic             id_ok;
    logic             wait_expired;

    // A claim is usable only if it names a real, in-range source.
    assign id_ok = (rsp_data_q[ID_W-1:0] != '0) && (rsp_data_q < 32'(NUM_SRC));

    // Final wait cycle: the counter is about to reach the timeout limit.
    assign wait_expired = (cnt_q == CNT_W'(RSP_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state, held-ID, wait-counter and status-counter logic.
    always_comb begin
        state_nx = state_q;
        id_nx    = id_q;
        cnt_nx   = cnt_q;
        spur_nx  = spurious_cnt_o;
        tmo_nx   = timeout_o;
        unique case (state_q)
            IDLE: begin
                if (ext_irq_i && irq_en_i) begin
                    state_nx = CLAIM_REQ;
                end
            end
            CLAIM_REQ: begin
                if (bus_gnt_i) begin
                    state_nx = CLAIM_WAIT;
                    cnt_nx   = '0;
                end
            end
            CLAIM_WAIT: begin
                // A response arriving in the final wait cycle beats the timeout.
                if (rsp_vld_q) begin
                    if (id_ok) begin
                        id_nx    = rsp_data_q[ID_W-1:0];
                        state_nx = DISPATCH;
                    end else begin
                        state_nx = IDLE;
                        if (spurious_cnt_o != 8'hFF) begin
                            spur_nx = spurious_cnt_o + 8'd1;
                        end
                    end
                end else if (wait_expired) begin
                    state_nx = IDLE;
                    tmo_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            DISPATCH: begin
                if (trap_ready_i) begin
                    state_nx = SERVICE;
                end
            end
            SERVICE: begin
                if (done_i) begin
                    state_nx = CMPL_REQ;
                end
            end
            CMPL_REQ: begin
                if (bus_gnt_i) begin
                    state_nx = CMPL_WAIT;
                    cnt_nx   = '0;
                end
            end
            CMPL_WAIT: begin
                if (rsp_vld_q) begin
                    state_nx = IDLE;
                end else if (wait_expired) begin
                    state_nx = IDLE;
                    tmo_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (state_nx == IDLE) begin
            id_nx  = '0;
            cnt_nx = '0;
        end
    end

    // Response capture, internal state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_vld_q      <= 1'b0;
            rsp_data_q     <= '0;
            id_q           <= '0;
            cnt_q          <= '0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= '0;
            bus_wdata_o    <= '0;
            trap_valid_o   <= 1'b0;
            trap_id_o      <= '0;
            busy_o         <= 1'b0;
            spurious_cnt_o <= '0;
            timeout_o      <= 1'b0;
        end else begin
            rsp_vld_q      <= bus_rvalid_i;
            rsp_data_q     <= bus_rdata_i;
            id_q           <= id_nx;
            cnt_q          <= cnt_nx;
            bus_req_o      <= (state_nx == CLAIM_REQ) || (state_nx == CMPL_REQ);
            bus_we_o       <= (state_nx == CMPL_REQ);
            bus_addr_o     <= CLAIM_ADDR;
            bus_wdata_o    <= ((state_nx == CMPL_REQ) || (state_nx == CMPL_WAIT))
                              ? 32'(id_nx) : 32'd0;
            trap_valid_o   <= (state_nx == DISPATCH);
            trap_id_o      <= id_nx;
            busy_o         <= (state_nx != IDLE);
            spurious_cnt_o <= spur_nx;
            timeout_o      <= tmo_nx;
        end
    end

endmodule

// File: tb/tb_irq_claim_ctrl.sv
// Self-checking bench for irq_claim_ctrl: table of claim responses plus
// hand-written sequences for stall, timeout, saturation and reset cases.
module tb_irq_claim_ctrl;

    localparam logic [31:0] EXP_ADDR = 32'h0020_0004;

    logic        clk;
    logic        rst;
    logic        ext_irq;
    logic        irq_en;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        trap_valid;
    logic        trap_ready;
    logic [4:0]  trap_id;
    logic        done;
    logic        busy;
    logic [7:0]  spur_cnt;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int unsigned exp_q[$];

    typedef struct {
        logic [31:0] rdata;
        bit          exp_trap;
        logic [4:0]  exp_id;
        logic [7:0]  exp_spur;
    } vec_t;

    vec_t vecs[7];

    irq_claim_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ext_irq_i      (ext_irq),
        .irq_en_i       (irq_en),
        .bus_req_o      (bus_req),
        .bus_gnt_i      (bus_gnt),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_wdata_o    (bus_wdata),
        .bus_rvalid_i   (bus_rvalid),
        .bus_rdata_i    (bus_rdata),
        .trap_valid_o   (trap_valid),
        .trap_ready_i   (trap_ready),
        .trap_id_o      (trap_id),
        .done_i         (done),
        .busy_o         (busy),
        .spurious_cnt_o (spur_cnt),
        .timeout_o      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One claim with a zero-wait bus; rdata is returned in the first wait cycle.
    task automatic do_claim(input logic [31:0] rd, input bit exp_trap, input logic [4:0] exp_id);
        ext_irq = 1'b1;
        irq_en  = 1'b1;
        tick();
        check("claim_req", 32'(bus_req), 32'd1);
        check("claim_we", 32'(bus_we), 32'd0);
        check("claim_addr", bus_addr, EXP_ADDR);
        ext_irq = 1'b0;
        irq_en  = 1'b0;
        tick();
        check("claim_req_drop", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = rd;
        if (exp_trap) exp_q.push_back(32'(exp_id));
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        check("trap_early", 32'(trap_valid), 32'd0);
        tick();
        check("trap_valid", 32'(trap_valid), 32'(exp_trap));
        check("claim_busy", 32'(busy), 32'(exp_trap));
        if (trap_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL trap_unexpected: got id %0d expected none", trap_id);
            end else begin
                check("trap_id", 32'(trap_id), exp_q.pop_front());
            end
        end
    endtask

    // Accept the trap, finish the handler, and acknowledge the completion write.
    task automatic complete(input logic [4:0] id);
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
        check("svc_trap_drop", 32'(trap_valid), 32'd0);
        check("svc_busy", 32'(busy), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("cmpl_req", 32'(bus_req), 32'd1);
        check("cmpl_we", 32'(bus_we), 32'd1);
        check("cmpl_wdata", bus_wdata, 32'(id));
        tick();
        check("cmpl_req_drop", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        tick();
        check("cmpl_idle", 32'(busy), 32'd0);
        check("cmpl_no_req", 32'(bus_req), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{32'd7,          1'b1, 5'd7,  8'd0};
        vecs[1] = '{32'd0,          1'b0, 5'd0,  8'd1};
        vecs[2] = '{32'd31,         1'b1, 5'd31, 8'd1};
        vecs[3] = '{32'd32,         1'b0, 5'd0,  8'd2};
        vecs[4] = '{32'd33,         1'b0, 5'd0,  8'd3};
        vecs[5] = '{32'd1,          1'b1, 5'd1,  8'd3};
        vecs[6] = '{32'h8000_0005,  1'b0, 5'd0,  8'd4};

        rst        = 1'b1;
        ext_irq    = 1'b0;
        irq_en     = 1'b0;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        trap_ready = 1'b0;
        done       = 1'b0;
        repeat (3) tick();
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trap", 32'(trap_valid), 32'd0);
        check("rst_spur", 32'(spur_cnt), 32'd0);
        check("rst_tmo", 32'(timeout), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Interrupt pending but masked: no claim.
        ext_irq = 1'b1;
        irq_en  = 1'b0;
        repeat (3) tick();
        check("masked_no_req", 32'(bus_req), 32'd0);
        check("masked_idle", 32'(busy), 32'd0);
        ext_irq = 1'b0;

        // Table of claim responses.
        for (int i = 0; i < 7; i++) begin
            do_claim(vecs[i].rdata, vecs[i].exp_trap, vecs[i].exp_id);
            check("vec_spur", 32'(spur_cnt), 32'(vecs[i].exp_spur));
            if (vecs[i].exp_trap) complete(vecs[i].exp_id);
        end

        // Response arrives in the very cycle the wait would expire.
        ext_irq = 1'b1;
        irq_en  = 1'b1;
        tick();
        ext_irq = 1'b0;
        tick();
        repeat (253) tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'd9;
        exp_q.push_back(32'd9);
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        tick();
        check("race_trap", 32'(trap_valid), 32'd1);
        check("race_tmo", 32'(timeout), 32'd0);
        if (exp_q.size() != 0) check("race_id", 32'(trap_id), exp_q.pop_front());
        complete(5'd9);

        // Core stalls the trap; done pulses in DISPATCH are ignored.
        do_claim(32'd12, 1'b1, 5'd12);
        for (int i = 0; i < 10; i++) begin
            done = (i == 3) || (i == 6);
            tick();
            done = 1'b0;
            check("hold_valid", 32'(trap_valid), 32'd1);
            check("hold_id", 32'(trap_id), 32'd12);
        end
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
        ext_irq = 1'b1;
        irq_en  = 1'b1;
        repeat (3) begin
            tick();
            check("no_nest_req", 32'(bus_req), 32'd0);
            check("no_nest_trap", 32'(trap_valid), 32'd0);
        end
        ext_irq = 1'b0;
        bus_gnt = 1'b0;
        done    = 1'b1;
        tick();
        done = 1'b0;
        repeat (3) begin
            check("cmpl_hold_req", 32'(bus_req), 32'd1);
            check("cmpl_hold_we", 32'(bus_we), 32'd1);
            check("cmpl_hold_wdata", bus_wdata, 32'd12);
            tick();
        end
        bus_gnt = 1'b1;
        tick();
        check("cmpl_granted", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        tick();
        check("stall_idle", 32'(busy), 32'd0);

        // Spurious counter saturation.
        for (int i = 0; i < 256; i++) do_claim(32'd0, 1'b0, 5'd0);
        check("spur_sat", 32'(spur_cnt), 32'd255);
        do_claim(32'd0, 1'b0, 5'd0);
        check("spur_stay", 32'(spur_cnt), 32'd255);

        // Claim response never arrives.
        ext_irq = 1'b1;
        irq_en  = 1'b1;
        tick();
        ext_irq = 1'b0;
        tick();
        check("tmo_wait_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd255);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_no_trap", 32'(trap_valid), 32'd0);
        check("tmo_spur", 32'(spur_cnt), 32'd255);
        do_claim(32'd5, 1'b1, 5'd5);
        complete(5'd5);
        check("tmo_sticky", 32'(timeout), 32'd1);

        // Reset during the completion wait.
        do_claim(32'd3, 1'b1, 5'd3);
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("pre_rst_wdata", bus_wdata, 32'd3);
        rst = 1'b1;
        #1;
        check("arst_req", 32'(bus_req), 32'd0);
        check("arst_we", 32'(bus_we), 32'd0);
        check("arst_addr", bus_addr, 32'd0);
        check("arst_wdata", bus_wdata, 32'd0);
        check("arst_trap", 32'(trap_valid), 32'd0);
        check("arst_id", 32'(trap_id), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_spur", 32'(spur_cnt), 32'd0);
        check("arst_tmo", 32'(timeout), 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            check("post_arst_req", 32'(bus_req), 32'd0);
            check("post_arst_busy", 32'(busy), 32'd0);
        end
        ext_irq = 1'b1;
        irq_en  = 1'b1;
        tick();
        check("post_arst_claim", 32'(bus_req), 32'd1);
        ext_irq = 1'b0;

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
